// File: rtl/status_led_ctrl_if.sv
// Control/status bundle between the board top level and status_led_ctrl.
// master drives modes, events and brightness; slave returns LED drive and the timebase.
interface status_led_ctrl_if #(
  parameter int NUM_LEDS = 2
);
  logic [2*NUM_LEDS-1:0] mode;
  logic [NUM_LEDS-1:0]   act_evt;
  logic [4*NUM_LEDS-1:0] brightness;
  logic [NUM_LEDS-1:0]   led;
  logic                  tick_1ms;
  logic                  tick_1s;
  logic [31:0]           uptime_sec;

  modport master (
    output mode, act_evt, brightness,
    input  led, tick_1ms, tick_1s, uptime_sec
  );

  modport slave (
    input  mode, act_evt, brightness,
    output led, tick_1ms, tick_1s, uptime_sec
  );
endinterface

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver with 1 ms / 1 s timebase and seconds uptime counter.
// Optional per-channel PWM dimming is built only when STATUS_LED_PWM_EN is defined.
module status_led_ctrl #(
  parameter int CLK_FREQ_HZ   = 125000000,
  parameter int NUM_LEDS      = 2,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int BLINK_HALF_MS = 500,
  parameter int STRETCH_MS    = 50
) (
  input logic               clk,
  input logic               rst_n,
  status_led_ctrl_if.slave  bus
);

  localparam int PRESC_N = CLK_FREQ_HZ / 1000;
  localparam int PW      = $clog2(PRESC_N);
  localparam logic [PW-1:0]       PRESC_LAST   = PW'(PRESC_N - 1);
  localparam logic [15:0]         BLINK_LAST   = 16'(BLINK_HALF_MS - 1);
  localparam logic [15:0]         STRETCH_LOAD = 16'(STRETCH_MS);
  localparam logic [NUM_LEDS-1:0] UNLIT        = ACTIVE_LOW ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

  logic [PW-1:0]               presc_p1;
  logic [9:0]                  ms_p1;
  logic                        tick_ms_p1;
  logic                        tick_s_p1;
  logic [31:0]                 uptime_p1;
  logic [15:0]                 blink_p1;
  logic                        phase_p0;
  logic                        phase_p1;
  logic [NUM_LEDS-1:0][15:0]   stretch_p0;
  logic [NUM_LEDS-1:0][15:0]   stretch_p1;
  logic [NUM_LEDS-1:0]         lit_p0;
  logic [NUM_LEDS-1:0]         gate_p0;
  logic [NUM_LEDS-1:0]         led_p1;

  // Timebase: prescaler -> registered 1 ms tick -> ms counter -> 1 s tick -> uptime
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_p1   <= '0;
      ms_p1      <= '0;
      tick_ms_p1 <= 1'b0;
      tick_s_p1  <= 1'b0;
      uptime_p1  <= '0;
      blink_p1   <= '0;
      phase_p1   <= 1'b0;
    end else begin
      tick_ms_p1 <= (presc_p1 == PRESC_LAST);
      tick_s_p1  <= (presc_p1 == PRESC_LAST) && (ms_p1 == 10'd999);
      presc_p1   <= (presc_p1 == PRESC_LAST) ? '0 : presc_p1 + 1'b1;
      if (tick_ms_p1) begin
        ms_p1    <= (ms_p1 == 10'd999) ? '0 : ms_p1 + 1'b1;
        blink_p1 <= (blink_p1 == BLINK_LAST) ? '0 : blink_p1 + 1'b1;
      end
      if (tick_s_p1) uptime_p1 <= uptime_p1 + 1'b1;
      phase_p1 <= phase_p0;
    end
  end

  assign phase_p0 = phase_p1 ^ (tick_ms_p1 && (blink_p1 == BLINK_LAST));

  // LED drive follows the next-state values so mode/event changes land in one cycle
  always_comb begin
    stretch_p0 = stretch_p1;
    lit_p0     = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.mode[2*i +: 2] != 2'd3)
        stretch_p0[i] = '0;
      else if (bus.act_evt[i])
        stretch_p0[i] = STRETCH_LOAD;
      else if (tick_ms_p1 && (stretch_p1[i] != '0))
        stretch_p0[i] = stretch_p1[i] - 1'b1;

      case (bus.mode[2*i +: 2])
        2'd0:    lit_p0[i] = 1'b0;
        2'd1:    lit_p0[i] = 1'b1;
        2'd2:    lit_p0[i] = phase_p0;
        default: lit_p0[i] = (stretch_p0[i] != '0);
      endcase
    end
  end

`ifdef STATUS_LED_PWM_EN
  logic [3:0] pwm_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_p1 <= '0;
    else        pwm_p1 <= pwm_p1 + 1'b1;
  end

  always_comb begin
    gate_p0 = '0;
    for (int i = 0; i < NUM_LEDS; i++)
      gate_p0[i] = (pwm_p1 < bus.brightness[4*i +: 4]);
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign gate_p0           = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stretch_p1 <= '0;
      led_p1     <= UNLIT;
    end else begin
      stretch_p1 <= stretch_p0;
      led_p1     <= (lit_p0 & gate_p0) ^ UNLIT;
    end
  end

  assign bus.led        = led_p1;
  assign bus.tick_1ms   = tick_ms_p1;
  assign bus.tick_1s    = tick_s_p1;
  assign bus.uptime_sec = uptime_p1;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Randomized scoreboard bench for status_led_ctrl against a time-based reference model.
// Define STATUS_LED_PWM_EN for both RTL and bench to exercise the dimming option.
module tb_status_led_ctrl;
  localparam int CLK_HZ = 4000;
  localparam int NL     = 2;
  localparam int P      = CLK_HZ / 1000;
  localparam int H      = 2;
  localparam int S      = 3;
  localparam bit AL     = 1'b1;
  localparam int BW     = 4 * NL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  status_led_ctrl_if #(.NUM_LEDS(NL)) bus();

  status_led_ctrl #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .NUM_LEDS     (NL),
    .ACTIVE_LOW   (AL),
    .BLINK_HALF_MS(H),
    .STRETCH_MS   (S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [NL-1:0] led;
    logic          t1;
    logic          ts;
    logic [31:0]   up;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          k      = 0;      // clock edges since reset release
  logic [31:0] base   = '0;     // uptime offset (nonzero only after the poke)
  int          expire [NL];     // ms-tick count at which each stretch ends

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", name, k, act, exp);
    end
  endtask

  // Expected outputs after edge k, derived from elapsed time and the current inputs
  task automatic predict();
    int            t;
    logic [1:0]    m;
    logic [NL-1:0] lit;
    exp_t          e;
    t   = (k - 1) / P;          // ms ticks already consumed by the counters
    lit = '0;
    for (int i = 0; i < NL; i++) begin
      m = bus.mode[2*i +: 2];
      if (m != 2'd3)            expire[i] = 0;
      else if (bus.act_evt[i])  expire[i] = t + S;
      case (m)
        2'd0:    lit[i] = 1'b0;
        2'd1:    lit[i] = 1'b1;
        2'd2:    lit[i] = ((t / H) % 2) == 1;
        default: lit[i] = (t < expire[i]);
      endcase
`ifdef STATUS_LED_PWM_EN
      if (((k - 1) % 16) >= int'(bus.brightness[4*i +: 4])) lit[i] = 1'b0;
`endif
    end
    e.led = AL ? ~lit : lit;
    e.t1  = (k % P) == 0;
    e.ts  = e.t1 && (((k / P) % 1000) == 0);
    e.up  = base + 32'((k - 1) / (1000 * P));
    sb.push_back(e);
  endtask

  task automatic step(input int n, input bit rnd);
    repeat (n) begin
      if (rnd) begin
        for (int i = 0; i < NL; i++) begin
          if ($urandom_range(79) == 0) bus.mode[2*i +: 2] = 2'($urandom_range(3));
          bus.act_evt[i] = ($urandom_range(11) == 0);
        end
        if ($urandom_range(499) == 0) bus.brightness = BW'($urandom);
      end
      k++;
      predict();
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_led"},    32'(bus.led),        32'(AL ? {NL{1'b1}} : {NL{1'b0}}));
    chk({tag, "_t1ms"},   32'(bus.tick_1ms),   32'd0);
    chk({tag, "_t1s"},    32'(bus.tick_1s),    32'd0);
    chk({tag, "_uptime"}, bus.uptime_sec,      32'd0);
  endtask

  task automatic restart();
    rst_n = 1'b1;
    k     = 0;
    base  = '0;
    for (int i = 0; i < NL; i++) expire[i] = 0;
  endtask

  // Monitor: one expected entry per active clock edge, compared after the edge
  always begin
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("led",      32'(bus.led),      32'(mon_e.led));
      chk("tick_1ms", 32'(bus.tick_1ms), 32'(mon_e.t1));
      chk("tick_1s",  32'(bus.tick_1s),  32'(mon_e.ts));
      chk("uptime",   bus.uptime_sec,    mon_e.up);
    end
  end

  initial begin
    bus.mode       = '0;
    bus.act_evt    = '0;
    bus.brightness = BW'($urandom);
    repeat (3) @(negedge clk);
    chk_reset("por");

    restart();
    step(13000, 1'b1);

    // Park uptime just below wrap in the middle of a second
    while ((k % (1000 * P)) != 2000) step(1, 1'b1);
    force dut.uptime_p1 = 32'hFFFF_FFFF;
    base = 32'hFFFF_FFFF - 32'((k - 1) / (1000 * P));
    #1 release dut.uptime_p1;
    step(4500, 1'b1);

    // Channel 0 blinking, channel 1 mid-stretch, then async reset between edges
    bus.mode    = {2'd3, 2'd2};
    bus.act_evt = 2'b10;
    step(1, 1'b0);
    bus.act_evt = 2'b00;
    step(3, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("async");
    repeat (2) @(negedge clk);
    chk_reset("held");

    restart();
    step(3000, 1'b1);

    @(posedge clk);
    #4 chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
